apb_cfg_master: RTL
===================

# apb_cfg_master

APB initiator that turns a simple valid/ready command stream into APB register transfers on an 8-bit-address, 32-bit-data bus. It sits between firmware/sequencer logic and the arbiter register block (ARB_CTRL @ 0x00, ARB_STATUS @ 0x04). It runs the SETUP/ACCESS phases, honours PReady wait states, and returns read data or an error on a response channel.

## Interface
Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; used only with APB_MST_TIMEOUT_EN

Ports:
- Pclk_i  in  1  clock; the only clock of the block
- PResetn_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  target register address
- cmd_wdata_i  in  DATA_W  write data; ignored for reads
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors
- rsp_err_o  out  1  PSlvErr seen or timeout
- PSel_o  out  1  APB select
- PEnable_o  out  1  APB enable
- PWrite_o  out  1  APB direction
- PAddr_o  out  ADDR_W  APB address
- PWData_o  out  DATA_W  APB write data
- PRData_i  in  DATA_W  APB read data
- PReady_i  in  1  APB ready; tie high for zero-wait slaves
- PSlvErr_i  in  1  APB slave error; tie low if unused

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready_o=1. When cmd_valid_i is high, capture write, addr, and wdata into PWrite_o/PAddr_o/PWData_o, then go to SETUP.
- SETUP: PSel_o=1, PEnable_o=0. Always go to ACCESS on the next cycle.
- ACCESS: PSel_o=1, PEnable_o=1. Leave only on PReady_i=1:
  - capture rsp_rdata_o = PRData_i for a read, or 0 for a write; if PSlvErr_i=1, rdata is also 0;
  - rsp_err_o = PSlvErr_i;
  - go to RESP.
- RESP: rsp_valid_o=1. Hold rsp_rdata_o and rsp_err_o until rsp_ready_i=1, then go to IDLE.
- PWrite_o, PAddr_o and PWData_o are stable from SETUP through the end of ACCESS. They keep their last value in IDLE and RESP.
- Only one transaction is outstanding; there is no command buffering.
- The address is passed through unchanged. Unmapped addresses are legal and are the slave's business.
- Reset (asynchronous, at any state, including mid-ACCESS): state=IDLE; all outputs 0, except cmd_ready_o=1 after reset release. An in-flight transaction is dropped and no response is produced.

## Timing
- All outputs are registered, or decoded directly from the state register.
- Command accepted at edge N:
  - SETUP during cycle N+1;
  - ACCESS during cycle N+2;
  - with PReady_i=1, rsp_valid_o is high from cycle N+3.
- Each wait state (PReady_i=0 in ACCESS) adds exactly one cycle.
- With rsp_ready_i held high, rsp_valid_o is high for one cycle, and the next command can be accepted at N+4. Peak throughput is one transfer per 4 cycles.
- PSel_o is never high in IDLE or RESP. PEnable_o is high only in ACCESS.

## Configuration
- APB_MST_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PReady_i=0.
  - At count TIMEOUT_CYCLES-1 with PReady_i still low, the block aborts: PSel_o and PEnable_o drop, then go to RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - PReady_i=1 on the abort cycle takes priority and completes normally.
- APB_MST_TIMEOUT_EN undefined: no counter logic; ACCESS waits for PReady_i indefinitely; TIMEOUT_CYCLES is unused.

## Structure
- Package apb_mst_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - ARB_CTRL_ADDR=8'h00 and ARB_STATUS_ADDR=8'h04;
  - the default ADDR_W and DATA_W localparams.
- One sub-module, apb_mst_wdog: the timeout counter with clear, count, and expired outputs. It is instantiated only under APB_MST_TIMEOUT_EN.

## Test plan
- Write 0x0000_00FF to 0x00, PReady_i tied high:
  - PSel_o rises the cycle after acceptance; PEnable_o rises one cycle later;
  - rsp_valid_o is high 3 cycles after acceptance with rsp_rdata_o=0 and rsp_err_o=0.
- Read 0x04 while PRData_i=0x0000_0307, PReady_i high: rsp_rdata_o=0x0000_0307 and rsp_err_o=0.
- Read with PReady_i low for 3 ACCESS cycles:
  - PAddr_o, PWrite_o and PSel_o stay stable throughout;
  - the response arrives 3 cycles later than the zero-wait case.
- PSlvErr_i=1 on the ready cycle of a read of 0x10: rsp_err_o=1 and rsp_rdata_o=0.
- With APB_MST_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, PReady_i stuck low: abort after 4 ACCESS cycles with rsp_err_o=1, and PSel_o low.
- Assert PResetn_i low mid-ACCESS, then hold rsp_ready_i low with a completed response pending:
  - the reset clears all outputs immediately and no response is produced;
  - in the held-response case, rsp_valid_o and its data are held and cmd_ready_o stays 0.

Source files
------------

// File: rtl/apb_mst_pkg.sv
// Shared types and constants for the APB configuration master: FSM states,
// arbiter register map and default bus widths.
package apb_mst_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    localparam logic [APB_ADDR_W-1:0] ARB_CTRL_ADDR   = 8'h00;
    localparam logic [APB_ADDR_W-1:0] ARB_STATUS_ADDR = 8'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/apb_mst_if.sv
// Command, response and APB bus signals of the configuration master, bundled
// with a master modport (the initiator) and a slave modport (its environment).
interface apb_mst_if
    import apb_mst_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic              PSel_o;
    logic              PEnable_o;
    logic              PWrite_o;
    logic [ADDR_W-1:0] PAddr_o;
    logic [DATA_W-1:0] PWData_o;
    logic [DATA_W-1:0] PRData_i;
    logic              PReady_i;
    logic              PSlvErr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
        input  PRData_i, PReady_i, PSlvErr_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output PSel_o, PEnable_o, PWrite_o, PAddr_o, PWData_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
        output PRData_i, PReady_i, PSlvErr_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  PSel_o, PEnable_o, PWrite_o, PAddr_o, PWData_o
    );

endinterface

// File: rtl/apb_mst_wdog.sv
// ACCESS-phase watchdog: clears on clr_i, counts while cnt_i is high and flags
// expired_o once TIMEOUT_CYCLES-1 stalled cycles have been counted.
module apb_mst_wdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic cnt_i,
    output logic expired_o
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (cnt_i && count_q != LAST)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/apb_cfg_master.sv
// APB initiator turning a valid/ready command stream into APB transfers.
// Optional ACCESS timeout is enabled by defining APB_MST_TIMEOUT_EN.
module apb_cfg_master
    import apb_mst_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic     Pclk_i,
    input  logic     PResetn_i,
    apb_mst_if.master bus
);
    state_e            state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              timeout;

`ifdef APB_MST_TIMEOUT_EN
    logic wdog_expired;

    apb_mst_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i     (Pclk_i),
        .rst_ni    (PResetn_i),
        .clr_i     (state_q == SETUP),
        .cnt_i     ((state_q == ACCESS) && !bus.PReady_i),
        .expired_o (wdog_expired)
    );

    assign timeout = wdog_expired && !bus.PReady_i;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    pwrite_d = bus.cmd_write_i;
                    paddr_d  = bus.cmd_addr_i;
                    pwdata_d = bus.cmd_wdata_i;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A ready slave wins over a timeout landing on the same cycle.
                if (bus.PReady_i) begin
                    rdata_d = (!pwrite_q && !bus.PSlvErr_i) ? bus.PRData_i : '0;
                    err_d   = bus.PSlvErr_i;
                    state_d = RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Pclk_i or negedge PResetn_i) begin
        if (!PResetn_i) begin
            state_q  <= IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Handshake and bus strobes decode straight from the state register;
    // cmd_ready is held low while reset is asserted.
    assign bus.cmd_ready_o = (state_q == IDLE) && PResetn_i;
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.PSel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.PEnable_o   = (state_q == ACCESS);
    assign bus.PWrite_o    = pwrite_q;
    assign bus.PAddr_o     = paddr_q;
    assign bus.PWData_o    = pwdata_q;

endmodule
